response_framer: RTL

RESPONSE_FRAMER -- requirements
Module: response_framer

---
 rtl/response_framer_pkg.sv | 22 ++
 rtl/response_framer_if.sv | 11 +
 rtl/response_framer_crc.sv | 19 +
 rtl/response_framer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/response_framer_pkg.sv
// Shared constants and state encoding for the response framer.
// Frames look like LEN, SEQ, payload, CRC high, CRC low, sync.
package response_framer_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'h7E;
    localparam logic [7:0]  SEQ_MARK  = 8'h10;
    localparam logic [7:0]  FRAME_OVH = 8'd5;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC_POLY  = 16'h8408;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_SEQ,
        ST_PAYLOAD,
        ST_CRC_HI,
        ST_CRC_LO,
        ST_SYNC,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/response_framer_if.sv
// Byte stream toward the USB/UART transmitter: valid/ready handshake.
interface response_framer_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/response_framer_crc.sv
// Combinational CRC-16 (reflected poly 0x8408) update by one byte.
module crc16_ccitt_byte
    import response_framer_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    always_comb begin
        logic [15:0] c;
        c = crc_in ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/response_framer.sv
// Frames queued responses (length FIFO + payload ring) into CRC-protected packets.
// Define FRAMER_STATS_EN to build the saturating frame/drop statistics counters.
module response_framer
    import response_framer_pkg::*;
#(
    parameter int LEN_BITS    = 8,
    parameter int MAX_PAYLOAD = 59
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LEN_BITS-1:0] len_data,
    input  logic                len_empty,
    output logic                len_rd_en,
    input  logic [7:0]          ring_data,
    input  logic                ring_empty,
    output logic                ring_rd_en,
    input  logic [3:0]          seq,
    response_framer_if.master   tx,
    output logic                drop,
    output logic [15:0]         frame_count,
    output logic [15:0]         drop_count
);

    localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(MAX_PAYLOAD);

    state_t              state;
    logic [LEN_BITS-1:0] len_q;
    logic [LEN_BITS-1:0] cnt_q;
    logic [LEN_BITS-1:0] cnt_inc;
    logic [3:0]          seq_q;
    logic [15:0]         crc_q;
    logic [15:0]         crc_nxt;
    logic [7:0]          tx_data_r;
    logic                tx_valid_r;
    logic                len_rd_en_r;
    logic                drop_r;
    logic                in_payload;
    logic                xfer;
    logic                drain_pop;

    // Payload bytes stream straight from the ring; header/trailer bytes come from registers.
    assign in_payload  = (state == ST_PAYLOAD);
    assign tx.tx_valid = in_payload ? !ring_empty : tx_valid_r;
    assign tx.tx_data  = in_payload ? ring_data : tx_data_r;
    assign xfer        = tx.tx_valid && tx.tx_ready;
    assign cnt_inc     = cnt_q + LEN_BITS'(1);
    assign drain_pop   = (state == ST_DRAIN) && (cnt_q != len_q) && !ring_empty;
    assign ring_rd_en  = (in_payload && xfer) || drain_pop;
    assign len_rd_en   = len_rd_en_r;
    assign drop        = drop_r;

    // The byte on the wire is always the byte folded into the CRC.
    crc16_ccitt_byte u_crc (
        .crc_in  (crc_q),
        .data_in (tx.tx_data),
        .crc_out (crc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            seq_q       <= '0;
            crc_q       <= CRC_INIT;
            tx_data_r   <= '0;
            tx_valid_r  <= 1'b0;
            len_rd_en_r <= 1'b0;
            drop_r      <= 1'b0;
        end else begin
            len_rd_en_r <= 1'b0;
            drop_r      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!len_empty) begin
                        len_q       <= len_data;
                        seq_q       <= seq;
                        cnt_q       <= '0;
                        crc_q       <= CRC_INIT;
                        len_rd_en_r <= 1'b1;
                        if (len_data == '0 || len_data > MAX_LEN) begin
                            state <= ST_DRAIN;
                        end else begin
                            state      <= ST_LEN;
                            tx_valid_r <= 1'b1;
                            tx_data_r  <= 8'(len_data) + FRAME_OVH;
                        end
                    end
                end
                ST_LEN: begin
                    if (xfer) begin
                        crc_q     <= crc_nxt;
                        tx_data_r <= SEQ_MARK | {4'h0, seq_q};
                        state     <= ST_SEQ;
                    end
                end
                ST_SEQ: begin
                    if (xfer) begin
                        crc_q      <= crc_nxt;
                        tx_valid_r <= 1'b0;
                        tx_data_r  <= '0;
                        state      <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer) begin
                        crc_q <= crc_nxt;
                        cnt_q <= cnt_inc;
                        if (cnt_inc == len_q) begin
                            tx_valid_r <= 1'b1;
                            tx_data_r  <= crc_nxt[15:8];
                            state      <= ST_CRC_HI;
                        end
                    end
                end
                ST_CRC_HI: begin
                    if (xfer) begin
                        tx_data_r <= crc_q[7:0];
                        state     <= ST_CRC_LO;
                    end
                end
                ST_CRC_LO: begin
                    if (xfer) begin
                        tx_data_r <= SYNC_BYTE;
                        state     <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (xfer) begin
                        tx_valid_r <= 1'b0;
                        tx_data_r  <= '0;
                        state      <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == len_q) begin
                        drop_r <= 1'b1;
                        state  <= ST_IDLE;
                    end else if (!ring_empty) begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FRAMER_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (state == ST_SYNC && xfer && frame_cnt_q != 16'hFFFF)
                frame_cnt_q <= frame_cnt_q + 16'd1;
            if (drop_r && drop_cnt_q != 16'hFFFF)
                drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
    assign drop_count  = drop_cnt_q;
`else
    assign frame_count = '0;
    assign drop_count  = '0;
`endif

endmodule
